// File: rtl/led_frame_sequencer_pkg.sv
// Shared types and defaults for the LED frame sequencer and its latch timer.
package led_pkg;

  localparam int COLOR_W_DEF      = 24;
  localparam int LATCH_CYCLES_DEF = 2500;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    LATCH  = 3'd4
  } state_t;

endpackage

// File: rtl/led_frame_sequencer_latch_timer.sv
// Loadable cycle timer: after load, active stays high for LATCH_CYCLES cycles and
// done is high during the last of them (registered look-ahead, no decode glitches).
module latch_timer
  import led_pkg::*;
#(
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF,
  localparam int CNT_W       = $clog2(LATCH_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATCH_CYCLES - 1);

  logic [CNT_W-1:0] count_r;
  logic             active_r;
  logic             done_r;

  // Count register; done is raised one cycle early so it coincides with the final count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {CNT_W{1'b0}};
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else if (load) begin
      count_r  <= {CNT_W{1'b0}};
      active_r <= 1'b1;
      done_r   <= (LAST == {CNT_W{1'b0}});
    end else if (active_r) begin
      if (count_r == LAST) begin
        active_r <= 1'b0;
        done_r   <= 1'b0;
      end else begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        done_r  <= ((count_r + {{(CNT_W-1){1'b0}}, 1'b1}) == LAST);
      end
    end
  end

  assign active = active_r;
  assign done   = done_r;

endmodule

// File: rtl/led_frame_sequencer.sv
// Per-frame sequencer: walks the colour mux, hands words to the LED serializer, then
// holds the latch gap. Define LED_AUTO_REFRESH_EN to repeat frames without a new start.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_PIX      = 8,
  parameter int SEL_W        = 3,
  parameter int COLOR_W      = COLOR_W_DEF,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic [COLOR_W-1:0] mux_data,
  output logic [COLOR_W-1:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               latch,
  output logic               frame_done
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_PIX - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [SEL_W-1:0]   index_r;
  logic [SEL_W-1:0]   mux_sel_r;
  logic [COLOR_W-1:0] pix_data_r;
  logic               pix_valid_r;
  logic               busy_r;
  logic               timer_load_s;
  logic               timer_done_s;
  logic               timer_active_s;
  logic               last_pix_s;

  assign last_pix_s = (index_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and latch timer kick-off.
  always_comb begin
    next_state_s = state_r;
    timer_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = SELECT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SELECT: next_state_s = LOAD;
      LOAD:   next_state_s = SEND;
      SEND: begin
        if (pix_ready && last_pix_s) begin
          next_state_s = LATCH;
          timer_load_s = 1'b1;
        end else if (pix_ready) begin
          next_state_s = SELECT;
        end else begin
          next_state_s = SEND;
        end
      end
      LATCH: begin
        if (timer_done_s) begin
`ifdef LED_AUTO_REFRESH_EN
          next_state_s = SELECT;
`else
          next_state_s = IDLE;
`endif
        end else begin
          next_state_s = LATCH;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath: mux_sel is updated on entry to SELECT so the mux settles through SELECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_r     <= {SEL_W{1'b0}};
      mux_sel_r   <= {SEL_W{1'b0}};
      pix_data_r  <= {COLOR_W{1'b0}};
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            index_r   <= {SEL_W{1'b0}};
            mux_sel_r <= {SEL_W{1'b0}};
          end
        end
        LOAD: begin
          pix_data_r  <= mux_data;
          pix_valid_r <= 1'b1;
        end
        SEND: begin
          if (pix_ready) begin
            pix_valid_r <= 1'b0;
            if (!last_pix_s) begin
              index_r   <= index_r + {{(SEL_W-1){1'b0}}, 1'b1};
              mux_sel_r <= index_r + {{(SEL_W-1){1'b0}}, 1'b1};
            end
          end
        end
        LATCH: begin
          if (timer_done_s && (next_state_s == SELECT)) begin
            index_r   <= {SEL_W{1'b0}};
            mux_sel_r <= {SEL_W{1'b0}};
          end
        end
        default: begin
          pix_valid_r <= 1'b0;
        end
      endcase
    end
  end

  latch_timer #(
    .LATCH_CYCLES (LATCH_CYCLES)
  ) u_latch_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load_s),
    .active (timer_active_s),
    .done   (timer_done_s)
  );

  assign busy       = busy_r;
  assign mux_sel    = mux_sel_r;
  assign pix_data   = pix_data_r;
  assign pix_valid  = pix_valid_r;
  assign latch      = timer_active_s;
  assign frame_done = timer_done_s;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed self-checking bench for led_frame_sequencer (main build: 8 pixels, 2500-cycle
// latch; second instance: 2 pixels, 1-cycle latch).
module tb_led_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic [2:0]  mux_sel;
  logic [23:0] mux_data;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        latch;
  logic        frame_done;

  logic        start2;
  logic        busy2;
  logic [0:0]  mux_sel2;
  logic [23:0] mux_data2;
  logic [23:0] pix_data2;
  logic        pix_valid2;
  logic        latch2;
  logic        frame_done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Upstream mux model: slot i carries colour i+1.
  assign mux_data  = {21'd0, mux_sel} + 24'd1;
  assign mux_data2 = {23'd0, mux_sel2} + 24'd1;

  led_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .mux_sel(mux_sel),
    .mux_data(mux_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .latch(latch), .frame_done(frame_done)
  );

  led_frame_sequencer #(.NUM_PIX(2), .SEL_W(1), .COLOR_W(24), .LATCH_CYCLES(1)) dut_short (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .mux_sel(mux_sel2),
    .mux_data(mux_data2), .pix_data(pix_data2), .pix_valid(pix_valid2),
    .pix_ready(1'b1), .latch(latch2), .frame_done(frame_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({busy, mux_sel, pix_data, pix_valid, latch, frame_done} !== 30'd0) begin
      bad++;
      $display("FAIL reset_async outputs=%h required=0",
               {busy, mux_sel, pix_data, pix_valid, latch, frame_done});
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || mux_sel !== 3'd0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release busy=%b mux_sel=%0d valid=%b required 0/0/0", busy, mux_sel, pix_valid);
    end
  endtask

  task automatic test_frame();
    int t;
    int n;
    int lat;
    int fd;
    int fdpos;
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL frame_busy got=%b required=1", busy);
    end
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!pix_valid && n < 10) begin tick(); t++; n++; end
      total++;
      if (t !== 2 + 3 * k || pix_data !== 24'(k + 1) || mux_sel !== 3'(k)) begin
        bad++;
        $display("FAIL frame_pixel%0d cycle=%0d data=%h sel=%0d required cycle=%0d data=%h sel=%0d",
                 k, t, pix_data, mux_sel, 2 + 3 * k, k + 1, k);
      end
      tick(); t++;
    end
    total++;
    if (pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL frame_valid_drop got=%b required=0", pix_valid);
    end
    lat = 0; fd = 0; fdpos = -1;
    while (latch && lat < 3000) begin
      if (frame_done) begin fd++; fdpos = lat; end
      tick(); lat++;
    end
    total++;
    if (lat !== 2500 || fd !== 1 || fdpos !== 2499) begin
      bad++;
      $display("FAIL frame_latch len=%0d done_pulses=%0d done_at=%0d required 2500/1/2499", lat, fd, fdpos);
    end
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL frame_idle busy=%b frame_done=%b required 0/0", busy, frame_done);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int held_bad;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!pix_valid && n < 10) begin tick(); n++; end
      if (k >= 5) begin
        total++;
        if (pix_data !== 24'(k + 1) || pix_valid !== 1'b1) begin
          bad++;
          $display("FAIL bp_pixel%0d data=%h valid=%b required data=%h valid=1", k, pix_data, pix_valid, k + 1);
        end
      end
      if (k == 5) begin
        pix_ready = 1'b0;
        held_bad = 0;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (pix_valid !== 1'b1 || pix_data !== 24'h000006 || mux_sel !== 3'd5) held_bad++;
        end
        total++;
        if (held_bad !== 0) begin
          bad++;
          $display("FAIL bp_hold unstable_cycles=%0d required=0 (last data=%h sel=%0d)", held_bad, pix_data, mux_sel);
        end
        pix_ready = 1'b1;
      end
      tick();
    end
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_frame_end busy=%b required=0", busy);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    int hs;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; hs = 0;
    while (!frame_done && n < 3000) begin
      if (pix_valid) hs++;
      start = (pix_valid && pix_data == 24'd3) || (latch && n == 500);
      tick(); n++;
    end
    total++;
    if (hs !== 8 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL ign_one_frame pixels=%0d frame_done=%b required 8/1", hs, frame_done);
    end
    start = 1'b1; tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_start_on_done busy=%b required=0", busy);
    end
    tick(); start = 1'b0;
    total++;
    if (busy !== 1'b1 || mux_sel !== 3'd0) begin
      bad++;
      $display("FAIL ign_start_after_done busy=%b sel=%0d required 1/0", busy, mux_sel);
    end
  endtask

  task automatic test_reset_mid_send();
    int n;
    n = 0;
    while (!(pix_valid && pix_data == 24'd4) && n < 30) begin tick(); n++; end
    pix_ready = 1'b0;
    total++;
    if (mux_sel !== 3'd3 || pix_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup sel=%0d valid=%b required 3/1", mux_sel, pix_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, mux_sel, pix_data, pix_valid, latch, frame_done} !== 30'd0) begin
      bad++;
      $display("FAIL rst_mid_send outputs=%h required=0",
               {busy, mux_sel, pix_data, pix_valid, latch, frame_done});
    end
    tick(); rst = 1'b0; pix_ready = 1'b1; tick();
    total++;
    if (busy !== 1'b0 || mux_sel !== 3'd0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_after busy=%b sel=%0d valid=%b required 0/0/0", busy, mux_sel, pix_valid);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0]  obs_valid;
    logic [7:0]  obs_latch;
    logic [7:0]  obs_done;
    logic [7:0]  obs_busy;
    logic [47:0] obs_data;
    obs_data = 48'd0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      obs_valid[t] = pix_valid2;
      obs_latch[t] = latch2;
      obs_done[t]  = frame_done2;
      obs_busy[t]  = busy2;
      if (pix_valid2) obs_data = {obs_data[23:0], pix_data2};
      tick();
    end
    total++;
    if (obs_valid !== 8'b0010_0100 || obs_data !== {24'h000001, 24'h000002}) begin
      bad++;
      $display("FAIL short_valid pattern=%b data=%h required 00100100 000001000002", obs_valid, obs_data);
    end
    total++;
    if (obs_latch !== 8'b0100_0000 || obs_done !== 8'b0100_0000) begin
      bad++;
      $display("FAIL short_latch latch=%b done=%b required 01000000/01000000", obs_latch, obs_done);
    end
    total++;
    if (obs_busy !== 8'b0111_1111) begin
      bad++;
      $display("FAIL short_busy pattern=%b required 01111111", obs_busy);
    end
  endtask

  task automatic test_auto_refresh();
    int fd;
    int drops;
    start = 1'b1; tick(); start = 1'b0;
    fd = 0; drops = 0;
    for (int i = 0; i < 3 * 2524; i++) begin
      if (frame_done) fd++;
      if (!busy) drops++;
      tick();
    end
    total++;
    if (fd !== 3 || drops !== 0) begin
      bad++;
      $display("FAIL auto_repeat frame_done=%0d busy_drops=%0d required 3/0", fd, drops);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    total++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL auto_halt busy=%b valid=%b required 0/0", busy, pix_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start2    = 1'b0;
    pix_ready = 1'b1;
    test_reset();
`ifdef LED_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_frame();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_send();
    test_short_frame();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Sequences the 8-way 24-bit colour mux once per frame.
- Steps the mux select through every pixel slot, registers each selected colour and hands it to the downstream LED serializer over a valid/ready handshake.
- After the last pixel, holds a latch/reset gap so the LED strip latches the frame.
- Sits between the colour mux (upstream) and the serial LED driver (downstream).

Parameters:
- NUM_PIX, 8, number of pixel slots sequenced per frame (2..2^SEL_W).
- SEL_W, 3, width of the mux select bus.
- COLOR_W, 24, colour word width.
- LATCH_CYCLES, 2500, length of the latch gap in clk cycles (50 us at 50 MHz); must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request, sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- mux_sel  out  SEL_W  select to the colour mux.
- mux_data  in  COLOR_W  mux output.
- pix_data  out  COLOR_W  registered colour word to the serializer.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  serializer accepts the word.
- latch  out  1  high during the latch gap.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.

Behaviour:
- Reset (async, active-high, any state):
  - state = IDLE; mux_sel = 0; pix_data = 0; pix_valid = 0; latch = 0; frame_done = 0; busy = 0.
  - Pixel index and latch counter are cleared.
  - An in-flight word is dropped; the serializer must tolerate pix_valid falling.
- FSM states: IDLE, SELECT, LOAD, SEND, LATCH.
- IDLE:
  - start=1 -> SELECT with index = 0.
  - start=0 -> stay in IDLE.
- SELECT:
  - mux_sel = index, registered.
  - Always -> LOAD next cycle; this gives one full cycle of mux settle time.
- LOAD:
  - pix_data <= mux_data, pix_valid <= 1.
  - -> SEND.
- SEND:
  - pix_valid stays high and pix_data is held stable until pix_ready=1 in the same cycle.
  - On that handshake, pix_valid <= 0.
  - If index == NUM_PIX-1 -> LATCH, counter <= 0. Otherwise index+1 -> SELECT.
- LATCH:
  - latch = 1; counter increments each cycle.
  - At counter == LATCH_CYCLES-1: latch <= 0, frame_done pulses 1 cycle, -> IDLE.
- Timing:
  - Latency from the start sample to first pix_valid = 2 cycles.
  - With pix_ready tied high, throughput = 3 cycles per pixel.
  - Total frame = 3*NUM_PIX + LATCH_CYCLES cycles + 1 (IDLE).
- start is ignored outside IDLE; it is not queued.
- A start in the same cycle that frame_done pulses (back in IDLE next cycle) is ignored; a start in the following cycle is honoured.
- pix_ready while pix_valid=0 has no effect.
- mux_sel holds its last value outside SELECT. The index never exceeds NUM_PIX-1, so no wrap-around occurs.
- Counter width = clog2(LATCH_CYCLES)+1; no overflow is possible.

Optional Feature:
- Macro: LED_AUTO_REFRESH_EN.
- Defined: at the end of LATCH the FSM goes directly to SELECT with index 0 (frame_done still pulses). Frames repeat continuously after the first start; only rst stops them.
- Undefined: the FSM returns to IDLE and waits for start, as above.

Decomposition:
- Shared package led_pkg holds:
  - COLOR_W default (24);
  - the FSM state enum (IDLE, SELECT, LOAD, SEND, LATCH);
  - the default LATCH_CYCLES constant.
- One sub-module is natural: latch_timer, a loadable down/up counter with a done pulse, parameterised by LATCH_CYCLES. It is reusable by the serializer for bit timing.

Test Plan:
- Reset mid-SEND (index 3, pix_valid=1): assert rst -> all outputs 0 asynchronously. After release, busy=0 and mux_sel=0.
- in0..in7 = 0x000001..0x000008, pix_ready tied 1, start pulse -> pix_data sequence 0x01..0x08, first pix_valid 2 cycles after the start sample, 3 cycles per pixel. latch is high for exactly 2500 cycles, then a single frame_done.
- Backpressure: pix_ready=0 for 10 cycles on pixel 5 -> pix_valid and pix_data=0x000006 held stable, mux_sel=5; the sequence then resumes with pixel 6.
- start pulsed during SEND and during LATCH -> ignored, exactly one frame emitted. start in the cycle after frame_done -> new frame begins.
- LATCH_CYCLES=1, NUM_PIX=2 -> latch high for 1 cycle, total frame 8 cycles.
- LED_AUTO_REFRESH_EN defined, single start -> frames repeat back-to-back, one frame_done per frame, busy never drops; rst halts the repetition.
